// File: rtl/ysyx_23060221_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ysyx_23060221_pkg                                                   |
// | Shared CLINT types: bus FSM state, AXI responses, word decode.     |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package ysyx_23060221_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RDATA = 2'd1,
        ST_WDATA = 2'd2,
        ST_WRESP = 2'd3
    } clint_state_t;

    localparam logic [1:0] c_OKAY   = 2'b00;
    localparam logic [1:0] c_SLVERR = 2'b10;
    localparam logic [1:0] c_DECERR = 2'b11;

    function automatic logic clint_mapped(input logic [31:0] addr, input logic [31:0] base);
        return (addr == base) || (addr == base + 32'd4);
    endfunction

    function automatic logic [31:0] clint_word(input logic [31:0] addr, input logic [31:0] base,
                                               input logic [63:0] val);
        if (addr == base)
            return val[31:0];
        else if (addr == base + 32'd4)
            return val[63:32];
        else
            return 32'd0;
    endfunction

    function automatic logic [1:0] clint_resp(input logic [31:0] addr, input logic [31:0] base);
        return clint_mapped(addr, base) ? c_OKAY : c_DECERR;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_23060221_mtime.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ysyx_23060221_mtime                                                 |
// | Prescaler plus free-running 64-bit mtime counter.                   |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module ysyx_23060221_mtime #(
    parameter int DIV = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [63:0] mtime
);

    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] c_PRE_MAX = PRE_W'(DIV - 1);

    logic [PRE_W-1:0] r_pre;
    logic [63:0]      r_mtime;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre   <= '0;
            r_mtime <= 64'd0;
        end else if (r_pre == c_PRE_MAX) begin
            r_pre   <= '0;
            r_mtime <= r_mtime + 64'd1;
        end else begin
            r_pre   <= r_pre + 1'b1;
        end
    end

    assign mtime = r_mtime;

endmodule
`default_nettype wire

// File: rtl/ysyx_23060221_clint.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ysyx_23060221_clint                                                 |
// | AXI4 slave serving coherent mtime snapshots; writes get SLVERR.     |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module ysyx_23060221_clint
    import ysyx_23060221_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int          DIV       = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clint_arvalid,
    input  logic [31:0] clint_araddr,
    input  logic [3:0]  clint_arid,
    input  logic [7:0]  clint_arlen,
    input  logic [2:0]  clint_arsize,
    input  logic [1:0]  clint_arburst,
    output logic        clint_arready,
    output logic        clint_rvalid,
    output logic [1:0]  clint_rresp,
    output logic [31:0] clint_rdata,
    output logic        clint_rlast,
    output logic [3:0]  clint_rid,
    input  logic        clint_rready,
    input  logic        clint_awvalid,
    input  logic [31:0] clint_awaddr,
    input  logic [3:0]  clint_awid,
    input  logic [7:0]  clint_awlen,
    input  logic [2:0]  clint_awsize,
    input  logic [1:0]  clint_awburst,
    output logic        clint_awready,
    input  logic        clint_wvalid,
    input  logic [31:0] clint_wdata,
    input  logic [3:0]  clint_wstrb,
    input  logic        clint_wlast,
    output logic        clint_wready,
    output logic        clint_bvalid,
    output logic [1:0]  clint_bresp,
    output logic [3:0]  clint_bid,
    input  logic        clint_bready
);

    logic [63:0]  w_mtime;
    clint_state_t r_state;
    logic         r_live;
    logic [63:0]  r_snap;
    logic [31:0]  r_addr;
    logic [7:0]   r_beats;
    logic [3:0]   r_id;
    logic         r_rvalid;
    logic [31:0]  r_rdata;
    logic [1:0]   r_rresp;
    logic         r_rlast;
    logic         r_bvalid;
    logic [1:0]   r_bresp;

    ysyx_23060221_mtime #(
        .DIV   (DIV)
    ) u_mtime (
        .clk   (clk),
        .rst_n (rst_n),
        .mtime (w_mtime)
    );

    // r_live keeps every ready low until the first clock after reset release.
    logic        w_idle;
    logic        w_ar_hs;
    logic        w_aw_hs;
    logic        w_r_hs;
    logic [31:0] w_next_addr;
    logic        w_unused;

    assign w_idle        = (r_state == ST_IDLE);
    assign clint_arready = r_live && w_idle;
    assign clint_awready = r_live && w_idle && !clint_arvalid;
    assign clint_wready  = r_live && (r_state == ST_WDATA);
    assign w_ar_hs       = clint_arvalid && clint_arready;
    assign w_aw_hs       = clint_awvalid && clint_awready;
    assign w_r_hs        = r_rvalid && clint_rready;
    assign w_next_addr   = r_addr + 32'd4;

    assign w_unused = ^{clint_arsize, clint_arburst, clint_awaddr, clint_awlen,
                        clint_awsize, clint_awburst, clint_wdata, clint_wstrb};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_live   <= 1'b0;
            r_snap   <= 64'd0;
            r_addr   <= 32'd0;
            r_beats  <= 8'd0;
            r_id     <= 4'd0;
            r_rvalid <= 1'b0;
            r_rdata  <= 32'd0;
            r_rresp  <= 2'b00;
            r_rlast  <= 1'b0;
            r_bvalid <= 1'b0;
            r_bresp  <= 2'b00;
        end else begin
            r_live <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_ar_hs) begin
                        // First beat is decoded straight from the live counter,
                        // which is the same value latched into the snapshot.
                        r_snap   <= w_mtime;
                        r_addr   <= clint_araddr;
                        r_beats  <= clint_arlen;
                        r_id     <= clint_arid;
                        r_rvalid <= 1'b1;
                        r_rdata  <= clint_word(clint_araddr, BASE_ADDR, w_mtime);
                        r_rresp  <= clint_resp(clint_araddr, BASE_ADDR);
                        r_rlast  <= (clint_arlen == 8'd0);
                        r_state  <= ST_RDATA;
                    end else if (w_aw_hs) begin
                        r_id     <= clint_awid;
                        r_state  <= ST_WDATA;
                    end
                end
                ST_RDATA: begin
                    if (w_r_hs) begin
                        if (r_beats == 8'd0) begin
                            r_rvalid <= 1'b0;
                            r_state  <= ST_IDLE;
                        end else begin
                            r_addr   <= w_next_addr;
                            r_beats  <= r_beats - 8'd1;
                            r_rdata  <= clint_word(w_next_addr, BASE_ADDR, r_snap);
                            r_rresp  <= clint_resp(w_next_addr, BASE_ADDR);
                            r_rlast  <= (r_beats == 8'd1);
                        end
                    end
                end
                ST_WDATA: begin
                    if (clint_wvalid && clint_wlast) begin
                        r_bvalid <= 1'b1;
                        r_bresp  <= c_SLVERR;
                        r_state  <= ST_WRESP;
                    end
                end
                ST_WRESP: begin
                    if (clint_bready) begin
                        r_bvalid <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign clint_rvalid = r_rvalid;
    assign clint_rdata  = r_rdata;
    assign clint_rresp  = r_rresp;
    assign clint_rlast  = r_rlast;
    assign clint_rid    = r_id;
    assign clint_bvalid = r_bvalid;
    assign clint_bresp  = r_bresp;
    assign clint_bid    = r_id;

endmodule
`default_nettype wire

// File: doc/ysyx_23060221_clint.md
# ysyx_23060221_clint

Core-local interruptor timer slave at the downstream end of the core's memory arbiter, on the arbiter's CLINT port. It keeps a free-running 64-bit `mtime` counter and serves it over a single-ID AXI4 slave interface. Reads of the two mapped words are coherent: every beat of one burst comes from the same 64-bit snapshot. Writes are accepted, drained and refused.

## Interface
- `BASE_ADDR`, default 32'h0200_0000: address of the `mtime` low word; the high word sits at `BASE_ADDR+4`. NPC builds set 32'ha000_0048.
- `DIV`, default 1: core clocks per `mtime` increment, DIV ≥ 1.
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `clint_ar{valid,addr,id,len,size,burst}` in 1/32/4/8/3/2: read address channel. `clint_arready` out 1.
- `clint_r{valid,resp,data,last,id}` out 1/2/32/1/4: read data channel. `clint_rready` in 1.
- `clint_aw{valid,addr,id,len,size,burst}` in 1/32/4/8/3/2: write address channel. `clint_awready` out 1.
- `clint_w{valid,data,strb,last}` in 1/32/4/1: write data channel. `clint_wready` out 1.
- `clint_b{valid,resp,id}` out 1/2/4: write response channel. `clint_bready` in 1.

## Operation
- **Prescaler and counter.**
  - `pre` counts 0..DIV-1.
  - When `pre==DIV-1`: `pre` returns to 0 and `mtime` increments by 1.
  - `mtime` wraps from 2^64-1 to 0.
  - The counter runs in every FSM state and is never stalled by bus traffic.
- **FSM states:** IDLE, RDATA, WDATA, WRESP.
- **IDLE.**
  - `arready=1`; `awready=!arvalid`, so reads have priority over writes.
  - AR handshake:
    - capture `snap<=mtime`; this is the current-cycle value, before any increment in that cycle;
    - capture `addr<=araddr`, `beats<=arlen`, `id<=arid`;
    - go to RDATA.
  - AW handshake (only possible with no `arvalid`): capture `id<=awid` and go to WDATA.
- **RDATA.**
  - Each beat drives:
    - `rdata`: `snap[31:0]` if `addr==BASE_ADDR`; `snap[63:32]` if `addr==BASE_ADDR+4`; otherwise 0;
    - `rresp`: 2'b00 OKAY for a mapped address; 2'b11 DECERR otherwise;
    - `rid=id`, `rlast=(beats==0)`.
  - On an R handshake:
    - if `beats==0`, go to IDLE;
    - else `addr<=addr+4` and `beats<=beats-1`.
  - `arsize` and `arburst` are ignored; every burst is treated as 4-byte INCR.
- **WDATA.** `wready=1`. Every W beat is discarded. The beat with `wlast=1` moves the FSM to WRESP.
- **WRESP.** `bvalid=1`, `bresp=2'b10` (SLVERR), `bid=id`. B handshake returns to IDLE.
- **Reset.**
  - Asserting `rst_n` low at any time, including mid-burst, forces IDLE immediately.
  - `mtime=0`, `pre=0`, `snap=0`.
  - `rvalid=0`, `rdata=0`, `rresp=0`, `rlast=0`, `rid=0`.
  - `bvalid=0`, `bresp=0`, `bid=0`.
  - `arready=awready=wready=0` while `rst_n` is low; the ready outputs take their IDLE values on the first cycle after release.

## Timing
- **Read latency.** AR handshake in cycle N, first beat with `rvalid=1` in cycle N+1.
- **Beat rate.** With `rready` held high, one beat per cycle. `arready` rises again the cycle after the `rlast` handshake.
- **Registered outputs.** `rvalid/rdata/rresp/rlast/rid` and `bvalid/bresp/bid` are registered. Each stays stable while its valid is high and the matching ready is low.
- **Back-to-back reads.** Minimum spacing is 2 cycles per single-beat read: AR, then R.
- **Write response.** Earliest B is the cycle after the `wlast` handshake. A W beat arriving in the same cycle as the AW handshake is not accepted, because `wready` is 0 in IDLE.
- **Snapshot coherence.** A 2-beat read (`arlen=1`) from `BASE_ADDR` returns low then high of one value, even if `mtime` carries across bit 31 between the beats.

## Structure
- The shared `ysyx_23060221_pkg` holds:
  - the FSM state typedef;
  - AXI response constants OKAY, SLVERR, DECERR.
- One natural sub-module, `ysyx_23060221_mtime`: prescaler plus 64-bit counter, with parameter `DIV` and output `mtime[63:0]`. The AXI FSM and snapshot logic stay in the top module.

## Test plan
- **Reset and counter, DIV=1.** Release `rst_n`, wait 10 cycles, single read of `BASE_ADDR` → `rdata` 32'd10 ±1 per the fixed capture point, `rresp=0`, `rlast=1`, `rid` equal to `arid`.
- **Prescaler, DIV=4.** Wait 40 cycles, then read the low word → value advanced by 10. Reading 2 cycles later returns the same value or +1.
- **Coherent 2-beat read.** Force `mtime=64'h0000_0000_FFFF_FFFF` (hierarchical deposit); `arlen=1` read at `BASE_ADDR` in that cycle → beats 32'hFFFF_FFFF then 32'h0, `rlast` only on the second beat.
- **Unmapped and back-pressure.** Read of `BASE_ADDR+8` → `rdata=0`, `rresp=2'b11`. Hold `rready=0` for 5 cycles → R outputs are stable and `arready` stays 0.
- **Write refusal.** AW with `awid=4'h3` and `awlen=1`, two W beats, second with `wlast=1` → `bvalid` the next cycle with `bresp=2'b10` and `bid=4'h3`; `mtime` is unchanged in value-trend.
- **Priority and reset mid-burst.**
  - `arvalid` and `awvalid` asserted together → AR is served first, `awready=0` that cycle.
  - Assert `rst_n` low during beat 1 of an `arlen=3` burst → `rvalid` drops immediately and `mtime` reads back near 0 after release.
